// File: rtl/round_gen.sv
// Round generator: picks a random target floor, shows it on a 7-seg digit, flags floor match and times each round.
// Outputs are combinational decodes of registered state (zero added latency); no backpressure, nextRound is a one-cycle pulse.
module round_gen #(
    parameter int          NUM_FLOORS = 6,
    parameter int          TIMEOUT    = 50_000_000,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       nextRound,
    input  logic [2:0] curFloor,
    output logic       FL,
    output logic [2:0] target,
    output logic [6:0] HEX,
    output logic       active,
    output logic       over
);
    localparam int          TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_WAIT,
        S_DONE,
        S_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      target_q, target_d;
    logic [2:0]      rounds_q, rounds_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [2:0]      cand;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            target_q <= 3'd0;
            rounds_q <= 3'd0;
            timer_q  <= '0;
            lfsr_q   <= SEED;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rounds_q <= rounds_d;
            timer_q  <= timer_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rounds_d = rounds_q;
        timer_d  = timer_q;
        // x^8+x^6+x^5+x^4+1, free-running so the pick depends on when the player starts
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cand     = lfsr_q[2:0];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PICK;
                    rounds_d = 3'd0;
                end
            end
            S_PICK: begin
                if (({1'b0, cand} < 4'(NUM_FLOORS)) && (cand != curFloor)) begin
                    target_d = cand;
                    timer_d  = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timer_q != TMAX) begin
                    timer_d = timer_q + TW'(1);
                end
                // a scored delivery wins over a timeout landing on the same edge
                if (nextRound) begin
                    rounds_d = rounds_q + 3'd1;
                    state_d  = (rounds_q == 3'd6) ? S_DONE : S_PICK;
                end else if (timer_q == TMAX) begin
                    state_d = S_OVER;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [6:0] seg_digit(input logic [2:0] d);
        case (d)
            3'd0:    seg_digit = 7'b1000000;
            3'd1:    seg_digit = 7'b1111001;
            3'd2:    seg_digit = 7'b0100100;
            3'd3:    seg_digit = 7'b0110000;
            3'd4:    seg_digit = 7'b0011001;
            3'd5:    seg_digit = 7'b0010010;
            3'd6:    seg_digit = 7'b0000010;
            default: seg_digit = 7'b1111000;
        endcase
    endfunction

    always_comb begin
        HEX = 7'b0111111;
        case (state_q)
            S_PICK:  HEX = 7'b1111111;
            S_WAIT:  HEX = seg_digit(target_q);
            S_DONE:  HEX = 7'b0100001;
            S_OVER:  HEX = 7'b0000110;
            default: HEX = 7'b0111111;
        endcase
    end

    assign FL     = (state_q == S_WAIT) && (curFloor == target_q);
    assign target = target_q;
    assign active = (state_q == S_PICK) || (state_q == S_WAIT);
    assign over   = (state_q == S_OVER);

endmodule

// File: tb/tb_round_gen.sv
// Bench for round_gen: vector table for reset/idle behaviour, scoreboarded target prediction for each round.
module tb_round_gen;
    localparam int         NF = 6;
    localparam int         TO = 16;
    localparam logic [7:0] SD = 8'hA5;

    localparam logic [6:0] H_DASH  = 7'b0111111;
    localparam logic [6:0] H_BLANK = 7'b1111111;
    localparam logic [6:0] H_D     = 7'b0100001;
    localparam logic [6:0] H_E     = 7'b0000110;

    logic       clk, reset, start, nextRound;
    logic [2:0] curFloor;
    logic       FL, active, over;
    logic [2:0] target;
    logic [6:0] HEX;

    round_gen #(.NUM_FLOORS(NF), .TIMEOUT(TO), .SEED(SD)) dut (
        .clk(clk), .reset(reset), .start(start), .nextRound(nextRound),
        .curFloor(curFloor), .FL(FL), .target(target), .HEX(HEX),
        .active(active), .over(over)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] tgt;
        int         picks;
    } pred_t;
    pred_t sb[$];

    typedef struct {
        logic       rst, st, nr;
        logic [2:0] cur;
        logic [6:0] hex;
        logic       act, ov, fl;
        logic [2:0] tgt;
    } vec_t;
    vec_t tbl[9];

    logic [7:0] m_lfsr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [6:0] digit(input logic [2:0] d);
        case (d)
            3'd0:    return 7'b1000000;
            3'd1:    return 7'b1111001;
            3'd2:    return 7'b0100100;
            3'd3:    return 7'b0110000;
            3'd4:    return 7'b0011001;
            3'd5:    return 7'b0010010;
            3'd6:    return 7'b0000010;
            default: return 7'b1111000;
        endcase
    endfunction

    // Reference LFSR running in lockstep with the design's
    always @(posedge clk) m_lfsr <= reset ? SD : lstep(m_lfsr);

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called while the edge that enters PICK is still ahead.
    task automatic predict();
        pred_t      p;
        logic [7:0] l;
        l = lstep(m_lfsr);
        p.picks = 1;
        while (!(({1'b0, l[2:0]} < 4'(NF)) && (l[2:0] != curFloor)) && p.picks < 300) begin
            l = lstep(l);
            p.picks++;
        end
        p.tgt = l[2:0];
        sb.push_back(p);
    endtask

    task automatic await_wait(input logic nr_pick);
        int    n;
        pred_t p;
        n = 0;
        while (active && HEX == H_BLANK && n < 300) begin
            n++;
            nextRound = nr_pick;
            tick();
        end
        nextRound = 1'b0;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: got WAIT with no prediction, expected a queued target");
            return;
        end
        p = sb.pop_front();
        chk("wait_reached", int'(active && !over && HEX != H_BLANK), 1);
        chk("pick_cycles", n, p.picks);
        chk("target", int'(target), int'(p.tgt));
        chk("hex_digit", int'(HEX), int'(digit(p.tgt)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        nextRound = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_game(input logic [2:0] cf);
        curFloor = cf;
        start = 1'b1;
        predict();
        tick();
        start = 1'b0;
    endtask

    task automatic score(input bit last);
        curFloor = target;
        settle();
        chk("fl_at_target", int'(FL), 1);
        nextRound = 1'b1;
        if (!last) predict();
        tick();
        nextRound = 1'b0;
        settle();
        if (last) begin
            chk("done_hex", int'(HEX), int'(H_D));
            chk("done_active", int'(active), 0);
        end else begin
            chk("next_pick_hex", int'(HEX), int'(H_BLANK));
            chk("next_pick_active", int'(active), 1);
            chk("next_pick_fl", int'(FL), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; nextRound = 1'b0; curFloor = 3'd0;
        //            rst st nr cur hex      act ov fl tgt
        tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd0, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 3'd0, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 3'd3, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 3'd5, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 3'd5, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 3'd0, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 3'd0, H_BLANK, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 3'd0, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 3'd2, H_DASH,  1'b0, 1'b0, 1'b0, 3'd0};

        for (int i = 0; i < 9; i++) begin
            reset = tbl[i].rst; start = tbl[i].st;
            nextRound = tbl[i].nr; curFloor = tbl[i].cur;
            tick();
            chk($sformatf("vec%0d_hex", i), int'(HEX), int'(tbl[i].hex));
            chk($sformatf("vec%0d_active", i), int'(active), int'(tbl[i].act));
            chk($sformatf("vec%0d_over", i), int'(over), int'(tbl[i].ov));
            chk($sformatf("vec%0d_fl", i), int'(FL), int'(tbl[i].fl));
            chk($sformatf("vec%0d_target", i), int'(target), int'(tbl[i].tgt));
        end
        reset = 1'b0; start = 1'b0; nextRound = 1'b0;

        // Idle holds with start low
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hex", int'(HEX), int'(H_DASH));
            chk("idle_active", int'(active), 0);
        end

        // Pick validity across many games with varied start timing
        for (int g = 0; g < 200; g++) begin
            do_reset();
            repeat ($urandom_range(0, 15)) tick();
            start_game(3'd2);
            await_wait(1'b0);
            chk("target_legal", int'(target < NF && target != 3'd2), 1);
        end

        // Floor match and scoring
        do_reset();
        start_game(3'd0);
        await_wait(1'b0);
        curFloor = target;
        settle();
        chk("fl_match", int'(FL), 1);
        curFloor = (target == 3'd5) ? 3'd0 : target + 3'd1;
        settle();
        chk("fl_away", int'(FL), 0);
        score(1'b0);
        await_wait(1'b0);

        // Full game, with nextRound pulses during every PICK that must be ignored
        do_reset();
        nextRound = 1'b1;
        tick();
        nextRound = 1'b0;
        start_game(3'd1);
        for (int r = 0; r < 7; r++) begin
            await_wait(1'b1);
            score(r == 6);
        end
        nextRound = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        nextRound = 1'b0;
        start = 1'b0;
        chk("done_hold_hex", int'(HEX), int'(H_D));
        chk("done_hold_active", int'(active), 0);
        chk("done_hold_over", int'(over), 0);

        // Timeout
        do_reset();
        start_game(3'd3);
        await_wait(1'b0);
        repeat (TO - 1) tick();
        chk("pre_timeout_active", int'(active), 1);
        chk("pre_timeout_over", int'(over), 0);
        tick();
        curFloor = target;
        settle();
        chk("timeout_over", int'(over), 1);
        chk("timeout_hex", int'(HEX), int'(H_E));
        chk("timeout_active", int'(active), 0);
        chk("timeout_fl", int'(FL), 0);
        start = 1'b1;
        nextRound = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        nextRound = 1'b0;
        chk("over_hold", int'(over), 1);

        // nextRound wins over timeout on the same edge
        do_reset();
        start_game(3'd3);
        await_wait(1'b0);
        repeat (TO - 1) tick();
        nextRound = 1'b1;
        predict();
        tick();
        nextRound = 1'b0;
        chk("prio_over", int'(over), 0);
        chk("prio_active", int'(active), 1);
        chk("prio_hex", int'(HEX), int'(H_BLANK));
        await_wait(1'b0);

        // Reset mid-round
        do_reset();
        start_game(3'd4);
        await_wait(1'b0);
        curFloor = target;
        settle();
        chk("mid_fl_before", int'(FL), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_hex", int'(HEX), int'(H_DASH));
        chk("mid_fl", int'(FL), 0);
        chk("mid_target", int'(target), 0);
        chk("mid_active", int'(active), 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/round_gen.md
# round_gen

Round generator for the elevator game. It picks a pseudo-random target floor, displays it on a seven-segment digit and asserts floor-match `FL` while the elevator sits at that floor. It also runs a per-round timeout. It drives the `FL` input of the scoring block and consumes that block's `nextRound` pulse to start the following round, ending the game after 7 scored rounds or on timeout.

## Interface
- `NUM_FLOORS`, default 6: valid floors are 0..NUM_FLOORS-1; legal range 2..8.
- `TIMEOUT`, default 50_000_000: cycles allowed per round before game over; must be ≥2.
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock; all state is sampled on posedge `clk`.
- `start`  in  1  begin a game; level or pulse, sampled in IDLE only.
- `nextRound`  in  1  one-cycle pulse from the scoring block when a delivery is scored.
- `curFloor`  in  3  elevator's current floor.
- `FL`  out  1  current floor equals target while a round is active (feeds scoring block).
- `target`  out  3  current target floor.
- `HEX`  out  7  active-low segments {g,f,e,d,c,b,a}.
- `active`  out  1  high in PICK and WAIT.
- `over`  out  1  high in OVER (timeout).

## Operation
States: IDLE, PICK, WAIT, DONE, OVER.

**Reset values:**
- state=IDLE, target=0, rounds=0, timer=0, lfsr=SEED.
- FL=0, active=0, over=0, HEX=7'b0111111 (dash).

**LFSR:**
- 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
- Shifts every cycle in every state except during reset.

**Transitions:**
- IDLE:
  - On `start`=1 → PICK; rounds cleared to 0.
  - Otherwise stay.
- PICK: candidate = lfsr[2:0].
  - If candidate < NUM_FLOORS and candidate != curFloor: target ← candidate, timer ← 0, → WAIT.
  - Otherwise stay in PICK and resample the next cycle.
- WAIT: timer increments each cycle.
  - `nextRound`=1: rounds ← rounds+1. If the new rounds == 7 → DONE, else → PICK.
  - Else if timer == TIMEOUT-1 → OVER.
  - `nextRound` has priority over timeout when both occur in the same cycle.
- DONE and OVER: terminal. Only `reset` leaves them; `start` and `nextRound` are ignored.

**Other rules:**
- `nextRound` is ignored in every state except WAIT. No count is kept and no state changes.
- The timer is wide enough for TIMEOUT-1 and saturates; it never wraps.
- `rounds` is 3 bits and never exceeds 7.
- FL = (state==WAIT) & (curFloor==target). Combinational from registered state/target and the `curFloor` input.
- `active` = state∈{PICK,WAIT}; `over` = state==OVER.

**HEX:**
- IDLE: dash 7'b0111111.
- PICK: blank 7'b1111111.
- WAIT: target digit.
- DONE: 'd' 7'b0100001.
- OVER: 'E' 7'b0000110.
- Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.

## Timing
- All state, target, timer, rounds and LFSR registers update on posedge `clk`.
- HEX, FL, `active` and `over` are combinational decodes of registered state. There is no added output latency.
- `start` sampled at edge N → PICK visible after edge N. Earliest WAIT is after edge N+1.
- Target is stable throughout WAIT. FL can therefore rise the same cycle `curFloor` changes to target.
- The scoring block registers `nextRound` one cycle after sampling FL. The resulting single-cycle pulse in WAIT causes exactly one increment.
- In WAIT, `timer` equals the number of completed WAIT cycles. OVER is entered on the edge where timer==TIMEOUT-1, so OVER is visible TIMEOUT cycles after WAIT entry.
- `reset` asserted in any state, mid-round included, returns all outputs to reset values on that edge. It has priority over `start`, `nextRound` and timeout.

## Test plan
- **Reset/idle:** reset 1 cycle, `start`=0 for 10 cycles → state IDLE, HEX=0111111, FL=0, active=0, over=0, target=0.
- **Pick validity:** NUM_FLOORS=6, curFloor=2, pulse `start`, repeat over 200 games with reset between → every target ∈{0,1,3,4,5}, HEX matches the target digit, PICK lasts ≥1 cycle.
- **Floor match:** in WAIT, drive curFloor to target → FL=1 that cycle; change curFloor away → FL=0. Pulse `nextRound` → PICK next cycle, FL=0, HEX=1111111.
- **Full game:** 7 `nextRound` pulses, one per WAIT → DONE, HEX=0100001, active=0. A further `nextRound` and `start` cause no change.
- **Timeout and priority:**
  - TIMEOUT=16, no `nextRound` → OVER exactly 16 cycles after WAIT entry, over=1, HEX=0000110.
  - Rerun with `nextRound` on the cycle timer==15 → PICK, not OVER.
- **Ignored pulses / mid-reset:** `nextRound` in IDLE and PICK → rounds unchanged, verified by 7 more pulses still being needed for DONE. `reset` during WAIT with FL=1 → next cycle IDLE, FL=0, target=0.
